// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: owns the HI/LO register pair for the EX stage.
// It decodes mult/multu/div/divu/mthi/mtlo, converts signed operands to
// magnitudes for the unsigned multiplier and divider, restores the result
// signs on writeback, and stalls the pipeline for dependent HI/LO accesses
// while an operation is in flight.
// Optional feature: define MULDIV_WATCHDOG_EN to add a divide watchdog that
// abandons a DIV after DIV_TIMEOUT cycles without Div_done.
module muldiv_hilo_ctrl #(
    parameter int MUL_LATENCY = 1
`ifdef MULDIV_WATCHDOG_EN
    , parameter int DIV_TIMEOUT = 64
`endif
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        Op_valid,
    input  logic [2:0]  Op_code,
    input  logic [31:0] Operand_a,
    input  logic [31:0] Operand_b,
    input  logic        Mf_req,
    input  logic        Mf_sel,
    output logic [31:0] Mf_data,
    output logic        Stall,
    output logic        Busy,
    output logic        Divide_zero,
    output logic        Div_timeout,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic [31:0] Mul_a,
    output logic [31:0] Mul_b,
    input  logic [63:0] Mul_product,
    output logic        Div_start,
    output logic [31:0] Div_dividend,
    output logic [31:0] Div_divisor,
    input  logic        Div_done,
    input  logic [31:0] Div_quotient,
    input  logic [31:0] Div_remainder
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2} state_t;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [63:0] neg64(input logic [63:0] x);
        return ~x + 64'd1;
    endfunction

    function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
        return (is_signed && x[31]) ? neg32(x) : x;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [31:0] div_dividend_q, div_dividend_d, div_divisor_q, div_divisor_d;
    logic [2:0]  mul_cnt_q, mul_cnt_d;
    logic        neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d;
    logic        div_start_q, div_start_d, divide_zero_q, divide_zero_d;
`ifdef MULDIV_WATCHDOG_EN
    logic [31:0] wdog_q, wdog_d;
    logic        div_timeout_q, div_timeout_d;
`endif

    logic        busy_s, stall_s, op_accept_s, op_signed_s;
    logic [31:0] a_mag_s, b_mag_s, quot_s, rem_s;
    logic [63:0] product_s;

    // Decode, operand magnitudes, sign-restored results and stall request
    always_comb begin
        busy_s      = (state_q != ST_IDLE);
        stall_s     = busy_s && (Mf_req || Op_valid);
        op_accept_s = Op_valid && !stall_s;
        op_signed_s = (Op_code == OP_MULT) || (Op_code == OP_DIV);
        a_mag_s     = mag32(Operand_a, op_signed_s);
        b_mag_s     = mag32(Operand_b, op_signed_s);
        product_s   = neg_quot_q ? neg64(Mul_product) : Mul_product;
        quot_s      = neg_quot_q ? neg32(Div_quotient) : Div_quotient;
        rem_s       = neg_rem_q ? neg32(Div_remainder) : Div_remainder;
    end

    // Sequencer next-state: accept ops in IDLE, count down MUL, wait for the divider
    always_comb begin
        state_d        = state_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        mul_a_d        = mul_a_q;
        mul_b_d        = mul_b_q;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;
        mul_cnt_d      = mul_cnt_q;
        neg_quot_d     = neg_quot_q;
        neg_rem_d      = neg_rem_q;
        div_start_d    = 1'b0;
        divide_zero_d  = 1'b0;
`ifdef MULDIV_WATCHDOG_EN
        wdog_d         = wdog_q;
        div_timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (op_accept_s) begin
                    case (Op_code)
                        OP_MULT, OP_MULTU: begin
                            mul_a_d    = a_mag_s;
                            mul_b_d    = b_mag_s;
                            neg_quot_d = op_signed_s && (Operand_a[31] ^ Operand_b[31]);
                            neg_rem_d  = 1'b0;
                            mul_cnt_d  = 3'(MUL_LATENCY);
                            state_d    = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (Operand_b != 32'd0) begin
                                div_dividend_d = a_mag_s;
                                div_divisor_d  = b_mag_s;
                                neg_quot_d     = op_signed_s && (Operand_a[31] ^ Operand_b[31]);
                                neg_rem_d      = (Op_code == OP_DIV) && Operand_a[31];
                                div_start_d    = 1'b1;
`ifdef MULDIV_WATCHDOG_EN
                                wdog_d         = 32'd0;
`endif
                                state_d        = ST_DIV;
                            end else begin
                                // Divide by zero leaves HI/LO untouched and never busies the unit
                                divide_zero_d  = 1'b1;
                            end
                        end
                        OP_MTHI: hi_d = Operand_a;
                        OP_MTLO: lo_d = Operand_a;
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_cnt_q == 3'd0) begin
                    hi_d    = product_s[63:32];
                    lo_d    = product_s[31:0];
                    state_d = ST_IDLE;
                end else begin
                    mul_cnt_d = mul_cnt_q - 3'd1;
                end
            end
            ST_DIV: begin
                // A done pulse coincident with our own start pulse is stale and ignored
                if (Div_done && !div_start_q) begin
                    lo_d    = quot_s;
                    hi_d    = rem_s;
                    state_d = ST_IDLE;
`ifdef MULDIV_WATCHDOG_EN
                end else if (wdog_q == 32'(DIV_TIMEOUT - 1)) begin
                    div_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 32'd1;
                end
`else
                end else begin
                    state_d = ST_DIV;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and HI/LO register update; reset discards any in-flight result
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            hi_q           <= 32'd0;
            lo_q           <= 32'd0;
            mul_a_q        <= 32'd0;
            mul_b_q        <= 32'd0;
            div_dividend_q <= 32'd0;
            div_divisor_q  <= 32'd0;
            mul_cnt_q      <= 3'd0;
            neg_quot_q     <= 1'b0;
            neg_rem_q      <= 1'b0;
            div_start_q    <= 1'b0;
            divide_zero_q  <= 1'b0;
`ifdef MULDIV_WATCHDOG_EN
            wdog_q         <= 32'd0;
            div_timeout_q  <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
            mul_cnt_q      <= mul_cnt_d;
            neg_quot_q     <= neg_quot_d;
            neg_rem_q      <= neg_rem_d;
            div_start_q    <= div_start_d;
            divide_zero_q  <= divide_zero_d;
`ifdef MULDIV_WATCHDOG_EN
            wdog_q         <= wdog_d;
            div_timeout_q  <= div_timeout_d;
`endif
        end
    end

    assign Mf_data      = Mf_sel ? hi_q : lo_q;
    assign Stall        = stall_s;
    assign Busy         = busy_s;
    assign Divide_zero  = divide_zero_q;
    assign Hi           = hi_q;
    assign Lo           = lo_q;
    assign Mul_a        = mul_a_q;
    assign Mul_b        = mul_b_q;
    assign Div_start    = div_start_q;
    assign Div_dividend = div_dividend_q;
    assign Div_divisor  = div_divisor_q;
`ifdef MULDIV_WATCHDOG_EN
    assign Div_timeout  = div_timeout_q;
`else
    assign Div_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl: behavioural multiplier and
// divider models, a scoreboard of expected {HI,LO} results, directed
// scenarios plus a few random mult/div operations.
module tb_muldiv_hilo_ctrl;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        Op_valid;
    logic [2:0]  Op_code;
    logic [31:0] Operand_a, Operand_b;
    logic        Mf_req, Mf_sel;
    logic [31:0] Mf_data;
    logic        Stall, Busy, Divide_zero, Div_timeout;
    logic [31:0] Hi, Lo, Mul_a, Mul_b;
    logic [63:0] Mul_product = 64'd0;
    logic        Div_start;
    logic [31:0] Div_dividend, Div_divisor;
    logic        Div_done = 1'b0;
    logic [31:0] Div_quotient = 32'd0, Div_remainder = 32'd0;

    logic        div_respond;
    logic [3:0]  dcnt = 4'd0;
    logic        dpend = 1'b0;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_hilo;

    muldiv_hilo_ctrl #(.MUL_LATENCY(1)) dut (
        .clock(clock), .reset_n(reset_n), .Op_valid(Op_valid), .Op_code(Op_code),
        .Operand_a(Operand_a), .Operand_b(Operand_b), .Mf_req(Mf_req), .Mf_sel(Mf_sel),
        .Mf_data(Mf_data), .Stall(Stall), .Busy(Busy), .Divide_zero(Divide_zero),
        .Div_timeout(Div_timeout), .Hi(Hi), .Lo(Lo), .Mul_a(Mul_a), .Mul_b(Mul_b),
        .Mul_product(Mul_product), .Div_start(Div_start), .Div_dividend(Div_dividend),
        .Div_divisor(Div_divisor), .Div_done(Div_done), .Div_quotient(Div_quotient),
        .Div_remainder(Div_remainder)
    );

    always #5 clock = ~clock;

    // One-cycle-latency unsigned multiplier model
    always @(posedge clock) Mul_product <= {32'd0, Mul_a} * {32'd0, Mul_b};

    // Divider model: Div_done rises 10 cycles after the rise of Div_start
    always @(posedge clock) begin
        Div_done <= 1'b0;
        if (Div_start && div_respond) begin
            dcnt          <= 4'd9;
            dpend         <= 1'b1;
            Div_quotient  <= Div_dividend / Div_divisor;
            Div_remainder <= Div_dividend % Div_divisor;
        end else if (dpend) begin
            if (dcnt == 4'd1) begin
                Div_done <= 1'b1;
                dpend    <= 1'b0;
            end else begin
                dcnt <= dcnt - 4'd1;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Architectural reference: {HI,LO} from two's-complement arithmetic
    function automatic logic [63:0] ref_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] sa, sb, sq, sr;
        sa = a;
        sb = b;
        case (code)
            OP_MULT: begin
                sp = 64'(sa) * 64'(sb);
                return sp;
            end
            OP_MULTU: return {32'd0, a} * {32'd0, b};
            OP_DIV: begin
                sq = sa / sb;
                sr = sa % sb;
                return {sr, sq};
            end
            OP_DIVU: return {a % b, a / b};
            default: return 64'd0;
        endcase
    endfunction

    task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        Op_valid = 1'b1; Op_code = code; Operand_a = a; Operand_b = b;
        @(posedge clock);
        #1;
        Op_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit done, output int stalls,
                             output int starts, output logic [31:0] dvd, output logic [31:0] dvs);
        done = 1'b0; stalls = 0; starts = 0; dvd = 32'd0; dvs = 32'd0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (Div_start) begin
                starts++;
                dvd = Div_dividend;
                dvs = Div_divisor;
            end
            if (!Busy) begin
                done = 1'b1;
                break;
            end
            if (Stall) stalls++;
        end
    endtask

    task automatic pop_check(input string tag, output logic [63:0] e);
        e = 64'd0;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_hi"}, {32'd0, Hi}, {32'd0, e[63:32]});
            check({tag, "_lo"}, {32'd0, Lo}, {32'd0, e[31:0]});
            exp_hilo = e;
        end
    endtask

    initial begin
        bit          done;
        int          stalls, starts, tcyc;
        logic [31:0] dvd, dvs, ra, rb;
        logic [2:0]  rc;
        logic [63:0] e;

        reset_n = 1'b0; Op_valid = 1'b0; Op_code = 3'd0; Operand_a = 32'd0; Operand_b = 32'd0;
        Mf_req = 1'b0; Mf_sel = 1'b0; div_respond = 1'b1; exp_hilo = 64'd0;
        repeat (2) @(negedge clock);
        check("rst_hi", Hi, 0);
        check("rst_lo", Lo, 0);
        check("rst_busy", Busy, 0);
        check("rst_divstart", Div_start, 0);
        check("rst_dz", Divide_zero, 0);
        check("rst_mula", Mul_a, 0);
        reset_n = 1'b1;

        // mult -6 * 7 with a pending mflo: 2 stall cycles
        Mf_req = 1'b1; Mf_sel = 1'b0;
        exp_q.push_back(ref_op(OP_MULT, 32'hFFFFFFFA, 32'd7));
        issue(OP_MULT, 32'hFFFFFFFA, 32'd7);
        wait_idle(20, done, stalls, starts, dvd, dvs);
        check("mult_done", done, 1);
        check("mult_stall", stalls, 2);
        pop_check("mult", e);
        check("mult_mf", Mf_data, {32'd0, e[31:0]});

        exp_q.push_back(ref_op(OP_MULTU, 32'hFFFFFFFA, 32'd7));
        issue(OP_MULTU, 32'hFFFFFFFA, 32'd7);
        wait_idle(20, done, stalls, starts, dvd, dvs);
        check("multu_done", done, 1);
        pop_check("multu", e);

        // signed div -7 / 2 with mflo waiting
        exp_q.push_back(ref_op(OP_DIV, 32'hFFFFFFF9, 32'd2));
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2);
        wait_idle(40, done, stalls, starts, dvd, dvs);
        check("div_done", done, 1);
        check("div_starts", starts, 1);
        check("div_dividend", dvd, 7);
        check("div_divisor", dvs, 2);
        check("div_stall", stalls, 11);
        pop_check("div", e);
        check("div_mf", Mf_data, {32'd0, e[31:0]});

        // divide by zero: HI preserved, no start, no stall
        issue(OP_MTHI, 32'h11111111, 32'd0);
        @(negedge clock);
        check("mthi_hi", Hi, 64'h11111111);
        issue(OP_DIV, 32'd5, 32'd0);
        @(negedge clock);
        check("dz_pulse", Divide_zero, 1);
        check("dz_nostart", Div_start, 0);
        check("dz_nostall", Stall, 0);
        @(negedge clock);
        check("dz_pulse_end", Divide_zero, 0);
        check("dz_hi", Hi, 64'h11111111);
        check("dz_nostall2", Stall, 0);

        // divu in flight, mthi held until the divide writes back
        Mf_req = 1'b0;
        exp_q.push_back(ref_op(OP_DIVU, 32'd100, 32'd7));
        issue(OP_DIVU, 32'd100, 32'd7);
        @(negedge clock);
        Op_valid = 1'b1; Op_code = OP_MTHI; Operand_a = 32'h12345678; Operand_b = 32'd0;
        #1;
        stalls = 0;
        done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!Stall) begin
                done = 1'b1;
                break;
            end
            stalls++;
            @(negedge clock);
        end
        check("mthi_release", done, 1);
        check("mthi_stall", stalls, 11);
        pop_check("divu", e);
        @(posedge clock);
        #1;
        Op_valid = 1'b0;
        @(negedge clock);
        check("mthi_after_hi", Hi, 64'h12345678);
        check("mthi_after_lo", Lo, {32'd0, e[31:0]});
        exp_hilo = {32'h12345678, e[31:0]};

        // reset in the middle of a divide; the late Div_done must be ignored
        issue(OP_DIV, 32'd9, 32'd3);
        repeat (3) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mrst_busy", Busy, 0);
        check("mrst_hi", Hi, 0);
        check("mrst_lo", Lo, 0);
        check("mrst_dvd", Div_dividend, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (15) @(negedge clock);
        check("late_done_busy", Busy, 0);
        check("late_done_hi", Hi, 0);
        check("late_done_lo", Lo, 0);

        // random mult/multu/div/divu against the reference
        for (int k = 0; k < 6; k++) begin
            rc = 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            if (rb == 32'd0 || rb == 32'hFFFFFFFF) rb = 32'd5;
            exp_q.push_back(ref_op(rc, ra, rb));
            issue(rc, ra, rb);
            wait_idle(40, done, stalls, starts, dvd, dvs);
            check("rnd_done", done, 1);
            pop_check("rnd", e);
        end

`ifdef MULDIV_WATCHDOG_EN
        div_respond = 1'b0;
        issue(OP_DIV, 32'd10, 32'd3);
        tcyc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (Div_timeout) begin
                tcyc = i;
                break;
            end
        end
        check("wd_cycle", tcyc, 64);
        check("wd_busy", Busy, 0);
        check("wd_hilo", {Hi, Lo}, exp_hilo);
        @(negedge clock);
        check("wd_pulse_end", Div_timeout, 0);
        div_respond = 1'b1;
`else
        tcyc = 0;
        check("dto_tied", Div_timeout, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
